unidade_controle_multiciclo: RTL and testbench

Multicycle MIPS main control unit: a Moore-style FSM that sequences the shared datapath (PC, memory, IR, register file, ALU, branch condition gate) one instruction at a time. It generates `pc_write_cond` and `pc_write_cond_ne`, which drive the `branch` and `branch_ne` inputs of the branch condition gate; ALU `zero` feeds back through that gate. It also waits on a memory-ready handshake.

---
 rtl/unidade_controle_multiciclo_pkg.sv | 75 +++++++
 rtl/unidade_controle_multiciclo_if.sv | 43 ++++
 rtl/unidade_controle_multiciclo_saidas.sv | 112 +++++++++++
 rtl/unidade_controle_multiciclo.sv | 79 +++++++
 tb/tb_unidade_controle_multiciclo.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, state
// encodings, datapath select codes and the bundle of control strobes.
package unidade_controle_multiciclo_pkg;

  // Opcodes (IR[31:26]) of the supported instructions
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // ALU operation requested from the ALU control block
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM states; encodings 13..15 are unused
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC      = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BEQ       = 4'd8,
    ST_BNE       = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EXEC = 4'd11,
    ST_ADDI_WB   = 4'd12
  } estado_t;

  // Every strobe and select the control unit drives
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_concluida;
    logic       instr_invalida;
    logic [3:0] estado;
  } sinais_t;

  // True for the opcodes this control unit knows how to sequence
  function automatic logic opcode_suportado(input logic [5:0] op);
    return (op == OP_R)   || (op == OP_LW)  || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J)  ||
           (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Control-unit <-> datapath signal bundle. The master side is the control
// unit (drives strobes, reads opcode and memory-ready); the slave side is
// the datapath.
interface unidade_controle_multiciclo_if;
  import unidade_controle_multiciclo_pkg::*;

  logic [5:0] opcode;
  logic       mem_pronto;

  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_write_cond_ne;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_concluida;
  logic       instr_invalida;
  logic [3:0] estado;

  modport master (
    input  opcode, mem_pronto,
    output pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read,
           mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_source, instr_concluida, instr_invalida,
           estado
  );

  modport slave (
    output opcode, mem_pronto,
    input  pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read,
           mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_source, instr_concluida, instr_invalida,
           estado
  );
endinterface

// File: rtl/unidade_controle_multiciclo_saidas.sv
// Moore output decoder for the multicycle control unit. Outputs depend on
// the current state only, except for the memory-ready qualification in
// FETCH / MEM_WRITE and the invalid-opcode pulse in DECODE.
module controle_saidas
  import unidade_controle_multiciclo_pkg::*;
(
  input  logic [3:0] estado,
  input  logic       mem_pronto,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  output sinais_t    sinais
);

  // Decode the current state into datapath strobes; reset forces all zero
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves an
    // output unassigned, which would otherwise infer a latch.
    sinais = '0;
    if (reset_n) begin
      sinais.estado = estado;
      case (estado)
        ST_FETCH: begin
          sinais.mem_read  = 1'b1;
          sinais.iord      = 1'b0;
          sinais.alu_src_a = 1'b0;
          sinais.alu_src_b = SRCB_4;
          sinais.alu_op    = ALU_ADD;
          sinais.pc_source = PCSRC_ALU;
          // IR and PC load only on the cycle the instruction word arrives
          sinais.ir_write  = mem_pronto;
          sinais.pc_write  = mem_pronto;
        end
        ST_DECODE: begin
          // Branch target precomputed into ALUOut while the opcode decodes
          sinais.alu_src_a = 1'b0;
          sinais.alu_src_b = SRCB_IMM_SH2;
          sinais.alu_op    = ALU_ADD;
          if (!opcode_suportado(opcode)) begin
            sinais.instr_invalida  = 1'b1;
            sinais.instr_concluida = 1'b1;
          end
        end
        ST_MEM_ADDR: begin
          sinais.alu_src_a = 1'b1;
          sinais.alu_src_b = SRCB_IMM;
          sinais.alu_op    = ALU_ADD;
        end
        ST_MEM_READ: begin
          sinais.mem_read = 1'b1;
          sinais.iord     = 1'b1;
        end
        ST_MEM_WB: begin
          sinais.reg_write       = 1'b1;
          sinais.mem_to_reg      = 1'b1;
          sinais.reg_dst         = 1'b0;
          sinais.instr_concluida = 1'b1;
        end
        ST_MEM_WRITE: begin
          sinais.mem_write       = 1'b1;
          sinais.iord            = 1'b1;
          sinais.instr_concluida = mem_pronto;
        end
        ST_EXEC: begin
          sinais.alu_src_a = 1'b1;
          sinais.alu_src_b = SRCB_B;
          sinais.alu_op    = ALU_FUNCT;
        end
        ST_ALU_WB: begin
          sinais.reg_write       = 1'b1;
          sinais.reg_dst         = 1'b1;
          sinais.mem_to_reg      = 1'b0;
          sinais.instr_concluida = 1'b1;
        end
        ST_BEQ: begin
          sinais.alu_src_a       = 1'b1;
          sinais.alu_src_b       = SRCB_B;
          sinais.alu_op          = ALU_SUB;
          sinais.pc_write_cond   = 1'b1;
          sinais.pc_source       = PCSRC_ALUOUT;
          sinais.instr_concluida = 1'b1;
        end
        ST_BNE: begin
          sinais.alu_src_a        = 1'b1;
          sinais.alu_src_b        = SRCB_B;
          sinais.alu_op           = ALU_SUB;
          sinais.pc_write_cond_ne = 1'b1;
          sinais.pc_source        = PCSRC_ALUOUT;
          sinais.instr_concluida  = 1'b1;
        end
        ST_JUMP: begin
          sinais.pc_write        = 1'b1;
          sinais.pc_source       = PCSRC_JUMP;
          sinais.instr_concluida = 1'b1;
        end
        ST_ADDI_EXEC: begin
          sinais.alu_src_a = 1'b1;
          sinais.alu_src_b = SRCB_IMM;
          sinais.alu_op    = ALU_ADD;
        end
        ST_ADDI_WB: begin
          sinais.reg_write       = 1'b1;
          sinais.reg_dst         = 1'b0;
          sinais.mem_to_reg      = 1'b0;
          sinais.instr_concluida = 1'b1;
        end
        // Unused encodings drive nothing, not even the debug state
        default: sinais = '0;
      endcase
    end
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS main control unit: state register and next-state logic,
// with the output decoding delegated to controle_saidas.
module unidade_controle_multiciclo
  import unidade_controle_multiciclo_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset_n,
  unidade_controle_multiciclo_if.master  ctrl
);

  estado_t estado_q, estado_d;
  sinais_t sinais;

  // State register with synchronous active-low reset into FETCH
  always_ff @(posedge clock) begin
    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (!reset_n) estado_q <= ST_FETCH;
    else          estado_q <= estado_d;
  end

  // Next-state selection from current state, opcode and memory-ready
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_FETCH:     if (ctrl.mem_pronto) estado_d = ST_DECODE;
      ST_DECODE: begin
        case (ctrl.opcode)
          OP_LW, OP_SW: estado_d = ST_MEM_ADDR;
          OP_R:         estado_d = ST_EXEC;
          OP_BEQ:       estado_d = ST_BEQ;
          OP_BNE:       estado_d = ST_BNE;
          OP_J:         estado_d = ST_JUMP;
          OP_ADDI:      estado_d = ST_ADDI_EXEC;
          default:      estado_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  estado_d = (ctrl.opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (ctrl.mem_pronto) estado_d = ST_MEM_WB;
      ST_MEM_WB:    estado_d = ST_FETCH;
      ST_MEM_WRITE: if (ctrl.mem_pronto) estado_d = ST_FETCH;
      ST_EXEC:      estado_d = ST_ALU_WB;
      ST_ALU_WB:    estado_d = ST_FETCH;
      ST_BEQ:       estado_d = ST_FETCH;
      ST_BNE:       estado_d = ST_FETCH;
      ST_JUMP:      estado_d = ST_FETCH;
      ST_ADDI_EXEC: estado_d = ST_ADDI_WB;
      ST_ADDI_WB:   estado_d = ST_FETCH;
      default:      estado_d = ST_FETCH;
    endcase
  end

  controle_saidas u_saidas (
    .estado     (estado_q),
    .mem_pronto (ctrl.mem_pronto),
    .reset_n    (reset_n),
    .opcode     (ctrl.opcode),
    .sinais     (sinais)
  );

  assign ctrl.pc_write         = sinais.pc_write;
  assign ctrl.pc_write_cond    = sinais.pc_write_cond;
  assign ctrl.pc_write_cond_ne = sinais.pc_write_cond_ne;
  assign ctrl.iord             = sinais.iord;
  assign ctrl.mem_read         = sinais.mem_read;
  assign ctrl.mem_write        = sinais.mem_write;
  assign ctrl.ir_write         = sinais.ir_write;
  assign ctrl.mem_to_reg       = sinais.mem_to_reg;
  assign ctrl.reg_dst          = sinais.reg_dst;
  assign ctrl.reg_write        = sinais.reg_write;
  assign ctrl.alu_src_a        = sinais.alu_src_a;
  assign ctrl.alu_src_b        = sinais.alu_src_b;
  assign ctrl.alu_op           = sinais.alu_op;
  assign ctrl.pc_source        = sinais.pc_source;
  assign ctrl.instr_concluida  = sinais.instr_concluida;
  assign ctrl.instr_invalida   = sinais.instr_invalida;
  assign ctrl.estado           = sinais.estado;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo. Each instruction is
// expanded into the cycle-by-cycle trace it must produce (inputs to drive
// and outputs expected); one loop replays the trace and compares.
module tb_unidade_controle_multiciclo;
  import unidade_controle_multiciclo_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  unidade_controle_multiciclo_if ctrl_if ();

  unidade_controle_multiciclo dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ctrl    (ctrl_if)
  );

  typedef struct packed {
    logic       reset_n;
    logic       mem_pronto;
    logic [5:0] opcode;
    sinais_t    exp;
  } ciclo_t;

  ciclo_t trace[$];
  int     vetores = 0;
  int     erros   = 0;

  task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    vetores++;
    if (atual !== esperado) begin
      erros++;
      $display("FAIL %s: got %h expected %h", nome, atual, esperado);
    end
  endtask

  // A normal (not in reset) cycle in debug state st, every strobe zero
  function automatic ciclo_t base(input logic [3:0] st, input logic mp, input logic [5:0] op);
    ciclo_t c;
    c = '0;
    c.reset_n    = 1'b1;
    c.mem_pronto = mp;
    c.opcode     = op;
    c.exp.estado = st;
    return c;
  endfunction

  function automatic ciclo_t em_reset(input logic mp);
    ciclo_t c;
    c = '0;
    c.mem_pronto = mp;
    return c;
  endfunction

  // Append the trace of one instruction. fetch_wait / mem_wait are cycles of
  // mem_pronto=0 before the access completes; aborta drops reset_n after
  // mem_wait cycles of the lw data read.
  task automatic add_instr(input logic [5:0] op, input int fetch_wait,
                           input int mem_wait, input bit aborta);
    ciclo_t c;
    bit     leitura;
    leitura = 1'b0;
    // instruction fetch: read at PC, PC+4 computed, loads on completion
    for (int i = 0; i <= fetch_wait; i++) begin
      c = base(4'd0, (i == fetch_wait), op);
      c.exp.mem_read  = 1'b1;
      c.exp.alu_src_b = 2'b01;
      c.exp.ir_write  = (i == fetch_wait);
      c.exp.pc_write  = (i == fetch_wait);
      trace.push_back(c);
    end
    // decode: branch target PC + (imm<<2)
    c = base(4'd1, 1'b1, op);
    c.exp.alu_src_b = 2'b11;
    if (!(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI})) begin
      c.exp.instr_invalida  = 1'b1;
      c.exp.instr_concluida = 1'b1;
      trace.push_back(c);
      return;
    end
    trace.push_back(c);
    if (op == OP_LW || op == OP_SW) begin
      c = base(4'd2, 1'b1, op);       // address A + imm
      c.exp.alu_src_a = 1'b1;
      c.exp.alu_src_b = 2'b10;
      trace.push_back(c);
      leitura = (op == OP_LW);
      for (int i = 0; i <= mem_wait; i++) begin
        if (aborta && i == mem_wait) begin
          trace.push_back(em_reset(1'b0));
          return;
        end
        c = base(leitura ? 4'd3 : 4'd5, (i == mem_wait), op);
        c.exp.iord      = 1'b1;
        c.exp.mem_read  = leitura;
        c.exp.mem_write = !leitura;
        c.exp.instr_concluida = !leitura && (i == mem_wait);
        trace.push_back(c);
      end
      if (leitura) begin
        c = base(4'd4, 1'b1, op);     // rt <- MDR
        c.exp.reg_write       = 1'b1;
        c.exp.mem_to_reg      = 1'b1;
        c.exp.instr_concluida = 1'b1;
        trace.push_back(c);
      end
    end else if (op == OP_R) begin
      c = base(4'd6, 1'b1, op);
      c.exp.alu_src_a = 1'b1;
      c.exp.alu_op    = 2'b10;
      trace.push_back(c);
      c = base(4'd7, 1'b1, op);       // rd <- ALUOut
      c.exp.reg_write       = 1'b1;
      c.exp.reg_dst         = 1'b1;
      c.exp.instr_concluida = 1'b1;
      trace.push_back(c);
    end else if (op == OP_ADDI) begin
      c = base(4'd11, 1'b1, op);
      c.exp.alu_src_a = 1'b1;
      c.exp.alu_src_b = 2'b10;
      trace.push_back(c);
      c = base(4'd12, 1'b1, op);      // rt <- ALUOut
      c.exp.reg_write       = 1'b1;
      c.exp.instr_concluida = 1'b1;
      trace.push_back(c);
    end else if (op == OP_BEQ || op == OP_BNE) begin
      c = base((op == OP_BEQ) ? 4'd8 : 4'd9, 1'b1, op);
      c.exp.alu_src_a        = 1'b1;
      c.exp.alu_op           = 2'b01;
      c.exp.pc_source        = 2'b01;
      c.exp.pc_write_cond    = (op == OP_BEQ);
      c.exp.pc_write_cond_ne = (op == OP_BNE);
      c.exp.instr_concluida  = 1'b1;
      trace.push_back(c);
    end else begin
      c = base(4'd10, 1'b1, op);      // j
      c.exp.pc_write        = 1'b1;
      c.exp.pc_source       = 2'b10;
      c.exp.instr_concluida = 1'b1;
      trace.push_back(c);
    end
  endtask

  // Append an instruction and pin the trace length and completion count
  task automatic add_pin(input string nome, input logic [5:0] op, input int fw,
                         input int mw, input bit ab, input int ciclos, input int pulsos);
    int inicio, n;
    inicio = trace.size();
    add_instr(op, fw, mw, ab);
    n = 0;
    for (int i = inicio; i < trace.size(); i++) n += int'(trace[i].exp.instr_concluida);
    check({nome, "_cycles"}, 64'(trace.size() - inicio), 64'(ciclos));
    check({nome, "_done_pulses"}, 64'(n), 64'(pulsos));
  endtask

  function automatic sinais_t dut_out();
    sinais_t s;
    s.pc_write         = ctrl_if.pc_write;
    s.pc_write_cond    = ctrl_if.pc_write_cond;
    s.pc_write_cond_ne = ctrl_if.pc_write_cond_ne;
    s.iord             = ctrl_if.iord;
    s.mem_read         = ctrl_if.mem_read;
    s.mem_write        = ctrl_if.mem_write;
    s.ir_write         = ctrl_if.ir_write;
    s.mem_to_reg       = ctrl_if.mem_to_reg;
    s.reg_dst          = ctrl_if.reg_dst;
    s.reg_write        = ctrl_if.reg_write;
    s.alu_src_a        = ctrl_if.alu_src_a;
    s.alu_src_b        = ctrl_if.alu_src_b;
    s.alu_op           = ctrl_if.alu_op;
    s.pc_source        = ctrl_if.pc_source;
    s.instr_concluida  = ctrl_if.instr_concluida;
    s.instr_invalida   = ctrl_if.instr_invalida;
    s.estado           = ctrl_if.estado;
    return s;
  endfunction

  initial begin
    reset_n           = 1'b0;
    ctrl_if.mem_pronto = 1'b1;
    ctrl_if.opcode    = 6'd0;

    // build the whole trace, pinning lengths against hand-computed CPI
    for (int i = 0; i < 3; i++) trace.push_back(em_reset(1'b1));
    add_pin("lw",       OP_LW,    0, 0, 1'b0, 5, 1);
    add_pin("sw_wait3", OP_SW,    0, 3, 1'b0, 7, 1);
    add_pin("rtype",    OP_R,     0, 0, 1'b0, 4, 1);
    add_pin("addi",     OP_ADDI,  0, 0, 1'b0, 4, 1);
    add_pin("beq",      OP_BEQ,   0, 0, 1'b0, 3, 1);
    add_pin("bne",      OP_BNE,   0, 0, 1'b0, 3, 1);
    add_pin("jump",     OP_J,     0, 0, 1'b0, 3, 1);
    add_pin("invalid",  6'b111111, 0, 0, 1'b0, 2, 1);
    add_pin("lw_fw2",   OP_LW,    2, 1, 1'b0, 8, 1);
    add_pin("lw_abort", OP_LW,    0, 2, 1'b1, 6, 0);
    add_pin("r_after",  OP_R,     0, 0, 1'b0, 4, 1);
    add_pin("bne_fw1",  OP_BNE,   1, 0, 1'b0, 4, 1);

    // replay: drive #1 after the edge, compare on the falling edge
    for (int k = 0; k < trace.size(); k++) begin
      @(posedge clock);
      #1;
      reset_n            = trace[k].reset_n;
      ctrl_if.mem_pronto = trace[k].mem_pronto;
      ctrl_if.opcode     = trace[k].opcode;
      @(negedge clock);
      check($sformatf("cycle%0d_outputs", k), 64'(dut_out()), 64'(trace[k].exp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
